// File: rtl/alu_uart_intf_pkg.sv
// Shared types and constants for the ALU <-> UART byte front/back end.
package alu_uart_intf_pkg;

    localparam int NB_BYTE  = 8;
    localparam int NB_SHAMT = 5;
    localparam logic [5:0] IDLE_OP = 6'b111111;

    typedef enum logic [2:0] {
        RX_OP    = 3'd0,
        RX_A     = 3'd1,
        RX_B     = 3'd2,
        RX_SHAMT = 3'd3,
        EXEC     = 3'd4,
        TX       = 3'd5,
        TX_WAIT  = 3'd6
    } state_e;

endpackage

// File: rtl/alu_uart_intf_if.sv
// UART RX/TX handshake plus ALU operand/result bus seen by alu_uart_intf (master side).
interface alu_uart_intf_if
    import alu_uart_intf_pkg::*;
#(
    parameter int NB_OP   = 6,
    parameter int NB_DATA = 8
);
    logic [NB_BYTE-1:0]  rx_data;
    logic                rx_valid;
    logic                tx_done;
    logic [NB_BYTE-1:0]  tx_data;
    logic                tx_start;
    logic [NB_OP-1:0]    alu_op;
    logic [NB_DATA-1:0]  alu_data_A;
    logic [NB_DATA-1:0]  alu_data_B;
    logic [NB_SHAMT-1:0] alu_shamt;
    logic [NB_DATA-1:0]  alu_result;

    modport master (
        input  rx_data, rx_valid, tx_done, alu_result,
        output tx_data, tx_start, alu_op, alu_data_A, alu_data_B, alu_shamt
    );

    modport slave (
        output rx_data, rx_valid, tx_done, alu_result,
        input  tx_data, tx_start, alu_op, alu_data_A, alu_data_B, alu_shamt
    );
endinterface

// File: rtl/alu_uart_intf_timeout.sv
// Idle-cycle counter for a partially received command; o_expire fires on the
// TIMEOUT_CYCLES-th consecutive enabled cycle without an accepted byte.
module alu_uart_intf_timeout #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_expire
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign o_expire = i_en && !i_clr && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!i_en || i_clr || o_expire) cnt_d = '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
endmodule

// File: rtl/alu_uart_intf.sv
// Byte-serial command collector and result returner between UART and ALU.
// Optional partial-command timeout: define ALU_UART_INTF_TIMEOUT_EN.
module alu_uart_intf
    import alu_uart_intf_pkg::*;
#(
    parameter int NB_OP          = 6,
    parameter int NB_DATA        = 8,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    alu_uart_intf_if.master bus,
    output logic           o_busy,
    output logic           o_drop
);
    localparam int BPW   = NB_DATA / 8;
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BPW - 1);

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [NB_OP-1:0]    op_q;
    logic [NB_DATA-1:0]  a_q, b_q, result_q;
    logic [NB_SHAMT-1:0] shamt_q;
    logic [NB_BYTE-1:0]  tx_data_q;
    logic                tx_start_q, drop_q;
    logic                accept, expire;

    function automatic logic [NB_BYTE-1:0] lane(input logic [NB_DATA-1:0] w,
                                                 input logic [CNT_W-1:0] idx);
        lane = '0;
        for (int i = 0; i < BPW; i++)
            if (idx == CNT_W'(i)) lane = w[i*8 +: 8];
    endfunction

    assign accept = bus.rx_valid && (state_q inside {RX_OP, RX_A, RX_B, RX_SHAMT});

`ifdef ALU_UART_INTF_TIMEOUT_EN
    logic to_en;
    assign to_en = (state_q inside {RX_A, RX_B, RX_SHAMT}) ||
                   (state_q == RX_OP && cnt_q != '0);

    alu_uart_intf_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_en     (to_en),
        .i_clr    (accept),
        .o_expire (expire)
    );
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= RX_OP;
            cnt_q      <= '0;
            op_q       <= NB_OP'(IDLE_OP);
            a_q        <= '0;
            b_q        <= '0;
            shamt_q    <= '0;
            result_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            drop_q     <= bus.rx_valid && (state_q inside {EXEC, TX, TX_WAIT});
            if (expire) begin
                state_q <= RX_OP;
                cnt_q   <= '0;
                op_q    <= NB_OP'(IDLE_OP);
            end else begin
                case (state_q)
                    RX_OP: if (bus.rx_valid) begin
                        op_q    <= bus.rx_data[NB_OP-1:0];
                        cnt_q   <= '0;
                        state_q <= RX_A;
                    end
                    RX_A: if (bus.rx_valid) begin
                        for (int i = 0; i < BPW; i++)
                            if (cnt_q == CNT_W'(i)) a_q[i*8 +: 8] <= bus.rx_data;
                        cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
                        if (cnt_q == LAST) state_q <= RX_B;
                    end
                    RX_B: if (bus.rx_valid) begin
                        for (int i = 0; i < BPW; i++)
                            if (cnt_q == CNT_W'(i)) b_q[i*8 +: 8] <= bus.rx_data;
                        cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
                        if (cnt_q == LAST) state_q <= RX_SHAMT;
                    end
                    RX_SHAMT: if (bus.rx_valid) begin
                        shamt_q <= bus.rx_data[NB_SHAMT-1:0];
                        state_q <= EXEC;
                    end
                    EXEC: begin
                        result_q <= bus.alu_result;
                        state_q  <= TX;
                    end
                    // counter selects the little-endian result byte being sent
                    TX: begin
                        tx_data_q  <= lane(result_q, cnt_q);
                        tx_start_q <= 1'b1;
                        state_q    <= TX_WAIT;
                    end
                    TX_WAIT: if (bus.tx_done) begin
                        if (cnt_q == LAST) begin
                            cnt_q   <= '0;
                            state_q <= RX_OP;
                        end else begin
                            cnt_q   <= cnt_q + 1'b1;
                            state_q <= TX;
                        end
                    end
                    default: state_q <= RX_OP;
                endcase
            end
        end
    end

    assign bus.tx_data    = tx_data_q;
    assign bus.tx_start   = tx_start_q;
    assign bus.alu_op     = op_q;
    assign bus.alu_data_A = a_q;
    assign bus.alu_data_B = b_q;
    assign bus.alu_shamt  = shamt_q;
    assign o_busy         = state_q inside {EXEC, TX, TX_WAIT};
    assign o_drop         = drop_q;
endmodule

// File: tb/tb_alu_uart_intf.sv
// Bench for alu_uart_intf: 8-bit and 32-bit instances fed by a small ALU model,
// result bytes checked against a queue of expected bytes.
module tb_alu_uart_intf;
    logic clk = 1'b0;
    logic rst_n;
    logic busy8, drop8, busy32, drop32;
    int   checks = 0;
    int   failures = 0;
    int   pushed = 0;
    int   starts = 0;
    logic [7:0] sb_q[$];

    alu_uart_intf_if #(.NB_OP(6), .NB_DATA(8))  bus8 ();
    alu_uart_intf_if #(.NB_OP(6), .NB_DATA(32)) bus32 ();

    alu_uart_intf #(.NB_OP(6), .NB_DATA(8), .TIMEOUT_CYCLES(16)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus8), .o_busy(busy8), .o_drop(drop8));
    alu_uart_intf #(.NB_OP(6), .NB_DATA(32), .TIMEOUT_CYCLES(16)) dut32 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus32), .o_busy(busy32), .o_drop(drop32));

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_model(input logic [5:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [4:0] sh,
                                              input int n);
        logic signed [31:0] sb;
        sb = $signed(b << (32 - n)) >>> (32 - n);
        case (op)
            6'h20, 6'h21: return a + b;
            6'h22, 6'h23: return a - b;
            6'h24:        return a & b;
            6'h25:        return a | b;
            6'h26:        return a ^ b;
            6'h27:        return ~(a | b);
            6'h00:        return b << sh;
            6'h02:        return b >> sh;
            6'h03:        return sb >>> sh;
            default:      return 32'h0;
        endcase
    endfunction

    assign bus8.alu_result  = 8'(alu_model(bus8.alu_op, 32'(bus8.alu_data_A),
                                           32'(bus8.alu_data_B), bus8.alu_shamt, 8));
    assign bus32.alu_result = alu_model(bus32.alu_op, bus32.alu_data_A,
                                        bus32.alu_data_B, bus32.alu_shamt, 32);

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus8.tx_start === 1'b1)  starts++;
        if (rst_n === 1'b1 && bus32.tx_start === 1'b1) starts++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic txs(input bit w);
        return w ? bus32.tx_start : bus8.tx_start;
    endfunction

    function automatic logic [7:0] txd(input bit w);
        return w ? bus32.tx_data : bus8.tx_data;
    endfunction

    task automatic push(input logic [7:0] b);
        sb_q.push_back(b);
        pushed++;
    endtask

    task automatic send_byte(input bit w, input logic [7:0] b);
        @(negedge clk);
        if (w) begin bus32.rx_data = b; bus32.rx_valid = 1'b1; end
        else   begin bus8.rx_data  = b; bus8.rx_valid  = 1'b1; end
        @(negedge clk);
        bus8.rx_valid  = 1'b0;
        bus32.rx_valid = 1'b0;
    endtask

    task automatic send_cmd(input bit w, input logic [7:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [7:0] sh);
        int bpw;
        bpw = w ? 4 : 1;
        send_byte(w, op);
        for (int i = 0; i < bpw; i++) send_byte(w, a[i*8 +: 8]);
        for (int i = 0; i < bpw; i++) send_byte(w, b[i*8 +: 8]);
        send_byte(w, sh);
    endtask

    task automatic tx_done_pulse(input bit w, input bit with_rx, input logic [7:0] b);
        @(negedge clk);
        if (w) begin bus32.tx_done = 1'b1; bus32.rx_valid = with_rx; bus32.rx_data = b; end
        else   begin bus8.tx_done  = 1'b1; bus8.rx_valid  = with_rx; bus8.rx_data  = b; end
        @(negedge clk);
        bus8.tx_done = 1'b0;  bus8.rx_valid = 1'b0;
        bus32.tx_done = 1'b0; bus32.rx_valid = 1'b0;
    endtask

    task automatic expect_tx(input bit w, input string name, input int exp_lat);
        int lat;
        logic [7:0] exp;
        lat = 0;
        while (txs(w) !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
        checks++;
        if (txs(w) !== 1'b1) begin
            failures++;
            $display("FAIL %s_start: tx_start not seen after %0d cycles, expected a pulse", name, lat);
        end else begin
            if (exp_lat >= 0) begin
                checks++;
                if (lat !== exp_lat) begin
                    failures++;
                    $display("FAIL %s_latency: got %0d cycles, expected %0d", name, lat, exp_lat);
                end
            end
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL %s_data: got %h with no byte expected", name, txd(w));
            end else begin
                exp = sb_q.pop_front();
                if (txd(w) !== exp) begin
                    failures++;
                    $display("FAIL %s_data: got %h, expected %h", name, txd(w), exp);
                end
            end
            @(negedge clk);
            checks++;
            if (txs(w) !== 1'b0) begin
                failures++;
                $display("FAIL %s_pulse: tx_start got %b one cycle later, expected 0", name, txs(w));
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus8.rx_data = '0;  bus8.rx_valid = 1'b0;  bus8.tx_done = 1'b0;
        bus32.rx_data = '0; bus32.rx_valid = 1'b0; bus32.tx_done = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus8.alu_op !== 6'h3F) begin failures++; $display("FAIL rst_op: got %h, expected 3f", bus8.alu_op); end
        checks++; if (bus8.alu_data_A !== 8'h00) begin failures++; $display("FAIL rst_A: got %h, expected 00", bus8.alu_data_A); end
        checks++; if (bus8.alu_data_B !== 8'h00) begin failures++; $display("FAIL rst_B: got %h, expected 00", bus8.alu_data_B); end
        checks++; if (bus8.alu_shamt !== 5'h00) begin failures++; $display("FAIL rst_shamt: got %h, expected 00", bus8.alu_shamt); end
        checks++; if (bus8.tx_data !== 8'h00) begin failures++; $display("FAIL rst_txdata: got %h, expected 00", bus8.tx_data); end
        checks++; if (bus8.tx_start !== 1'b0) begin failures++; $display("FAIL rst_txstart: got %b, expected 0", bus8.tx_start); end
        checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b, expected 0", busy8); end
        checks++; if (drop8 !== 1'b0) begin failures++; $display("FAIL rst_drop: got %b, expected 0", drop8); end
        checks++; if (bus32.alu_op !== 6'h3F) begin failures++; $display("FAIL rst_op32: got %h, expected 3f", bus32.alu_op); end
        checks++; if (bus32.alu_data_A !== 32'h0) begin failures++; $display("FAIL rst_A32: got %h, expected 0", bus32.alu_data_A); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_ops();
        push(8'h08);
        send_cmd(1'b0, 8'h20, 32'h05, 32'h03, 8'h00);
        checks++; if (bus8.alu_op !== 6'h20) begin failures++; $display("FAIL add_op: got %h, expected 20", bus8.alu_op); end
        checks++; if (bus8.alu_data_A !== 8'h05) begin failures++; $display("FAIL add_A: got %h, expected 05", bus8.alu_data_A); end
        checks++; if (bus8.alu_data_B !== 8'h03) begin failures++; $display("FAIL add_B: got %h, expected 03", bus8.alu_data_B); end
        expect_tx(1'b0, "add", 2);
        checks++; if (busy8 !== 1'b1) begin failures++; $display("FAIL add_busy_wait: got %b, expected 1", busy8); end
        tx_done_pulse(1'b0, 1'b0, 8'h00);
        checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL add_busy_done: got %b, expected 0", busy8); end

        push(8'hFE);
        send_cmd(1'b0, 8'h22, 32'h03, 32'h05, 8'h00);
        expect_tx(1'b0, "sub", 2);
        tx_done_pulse(1'b0, 1'b0, 8'h00);

        push(8'hE0);
        send_cmd(1'b0, 8'h03, 32'h00, 32'h80, 8'hE2);
        checks++; if (bus8.alu_shamt !== 5'd2) begin failures++; $display("FAIL sra_shamt: got %0d, expected 2", bus8.alu_shamt); end
        expect_tx(1'b0, "sra", 2);
        tx_done_pulse(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_wide();
        push(8'h79); push(8'h56); push(8'h34); push(8'h12);
        send_cmd(1'b1, 8'h21, 32'h12345678, 32'h00000001, 8'h00);
        checks++; if (bus32.alu_data_A !== 32'h12345678) begin failures++; $display("FAIL wide_A: got %h, expected 12345678", bus32.alu_data_A); end
        checks++; if (bus32.alu_data_B !== 32'h00000001) begin failures++; $display("FAIL wide_B: got %h, expected 00000001", bus32.alu_data_B); end
        for (int i = 0; i < 4; i++) begin
            expect_tx(1'b1, "wide", (i == 0) ? 2 : 1);
            repeat (3) @(negedge clk);
            checks++;
            if (bus32.tx_start !== 1'b0) begin failures++; $display("FAIL wide_hold_start: got %b before tx_done, expected 0", bus32.tx_start); end
            tx_done_pulse(1'b1, 1'b0, 8'h00);
        end
        checks++; if (busy32 !== 1'b0) begin failures++; $display("FAIL wide_busy_done: got %b, expected 0", busy32); end
    endtask

    task automatic test_drop();
        push(8'hFF);
        send_cmd(1'b0, 8'h25, 32'h0F, 32'hF0, 8'h00);
        expect_tx(1'b0, "or", 2);
        send_byte(1'b0, 8'hAA);
        checks++; if (drop8 !== 1'b1) begin failures++; $display("FAIL drop_pulse: got %b, expected 1", drop8); end
        checks++; if (bus8.tx_data !== 8'hFF) begin failures++; $display("FAIL drop_txdata: got %h, expected ff", bus8.tx_data); end
        @(negedge clk);
        checks++; if (drop8 !== 1'b0) begin failures++; $display("FAIL drop_width: got %b, expected 0", drop8); end
        checks++; if (busy8 !== 1'b1) begin failures++; $display("FAIL drop_busy: got %b, expected 1", busy8); end
        tx_done_pulse(1'b0, 1'b0, 8'h00);

        push(8'h44); push(8'h33); push(8'h22); push(8'h11);
        send_cmd(1'b1, 8'h26, 32'h11223344, 32'h0, 8'h00);
        expect_tx(1'b1, "xor", 2);
        tx_done_pulse(1'b1, 1'b1, 8'hAA);
        checks++; if (drop32 !== 1'b1) begin failures++; $display("FAIL simul_drop: got %b, expected 1", drop32); end
        expect_tx(1'b1, "simul_adv", 1);
        for (int i = 0; i < 2; i++) begin
            tx_done_pulse(1'b1, 1'b0, 8'h00);
            expect_tx(1'b1, "xor_tail", 1);
        end
        tx_done_pulse(1'b1, 1'b0, 8'h00);
        checks++; if (busy32 !== 1'b0) begin failures++; $display("FAIL xor_busy_done: got %b, expected 0", busy32); end
    endtask

    task automatic test_reset_mid();
        send_byte(1'b0, 8'h20);
        send_byte(1'b0, 8'h05);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        checks++; if (bus8.alu_op !== 6'h3F) begin failures++; $display("FAIL midrst_op: got %h, expected 3f", bus8.alu_op); end
        checks++; if (bus8.alu_data_A !== 8'h00) begin failures++; $display("FAIL midrst_A: got %h, expected 00", bus8.alu_data_A); end
        push(8'h08);
        send_cmd(1'b0, 8'h20, 32'h05, 32'h03, 8'h00);
        expect_tx(1'b0, "midrst_add", 2);
        tx_done_pulse(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_ignored_done();
        tx_done_pulse(1'b0, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL idle_done_busy: got %b, expected 0", busy8); end
    endtask

`ifdef ALU_UART_INTF_TIMEOUT_EN
    task automatic test_timeout();
        send_byte(1'b0, 8'h20);
        repeat (20) @(negedge clk);
        checks++; if (bus8.alu_op !== 6'h3F) begin failures++; $display("FAIL timeout_op: got %h, expected 3f", bus8.alu_op); end
        push(8'h0C);
        send_cmd(1'b0, 8'h24, 32'h0F, 32'h3C, 8'h00);
        expect_tx(1'b0, "timeout_and", 2);
        tx_done_pulse(1'b0, 1'b0, 8'h00);
    endtask
`endif

    initial begin
        test_reset();
        test_basic_ops();
        test_wide();
        test_drop();
        test_reset_mid();
        test_ignored_done();
`ifdef ALU_UART_INTF_TIMEOUT_EN
        test_timeout();
`endif
        repeat (5) @(negedge clk);
        checks++;
        if (starts !== pushed) begin failures++; $display("FAIL start_count: got %0d tx_start cycles, expected %0d", starts, pushed); end
        checks++;
        if (sb_q.size() !== 0) begin failures++; $display("FAIL scoreboard_left: got %0d bytes pending, expected 0", sb_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_uart_intf.md
Name: alu_uart_intf

Overview:
- Sequential front/back end for the ALU: collects operation, operand A, operand B and shift amount as bytes from the UART receiver.
- Drives the ALU inputs from registers, captures the ALU result, and returns it byte-by-byte through the UART transmitter.
- Sits between the UART RX/TX pair and the combinational ALU. The ALU is instantiated alongside, not inside, this block.

Parameters:
- NB_OP, 6, ALU opcode width.
- NB_DATA, 8, operand/result width; multiple of 8, at least 8.
- NB_BYTE, 8, UART frame width (fixed at 8).
- TIMEOUT_CYCLES, 1_000_000, idle-cycle limit for the optional timeout.

Ports:
- i_clk  in  1  system clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_rx_data  in  NB_BYTE  received byte, valid with i_rx_valid
- i_rx_valid  in  1  one-cycle pulse per received byte
- i_tx_done  in  1  one-cycle pulse when the TX frame is finished
- o_tx_data  out  NB_BYTE  byte to transmit, held stable until i_tx_done
- o_tx_start  out  1  one-cycle pulse to start a TX frame
- o_alu_op  out  NB_OP  registered ALU opcode
- o_alu_data_A  out  NB_DATA  registered operand A
- o_alu_data_B  out  NB_DATA  registered operand B
- o_alu_shamt  out  5  registered shift amount
- i_alu_result  in  NB_DATA  ALU combinational result
- o_busy  out  1  high in EXEC, TX and TX_WAIT
- o_drop  out  1  one-cycle pulse when a received byte is discarded

Behaviour:
- Reset (async, i_rst_n=0):
  - State is RX_OP.
  - o_alu_op=6'b111111 (ALU idle op); o_alu_data_A, o_alu_data_B, o_alu_shamt, o_tx_data = 0.
  - o_tx_start, o_busy, o_drop = 0.
  - Byte counter and result register = 0.
  - Reset mid-operation abandons the partial command and any pending TX; no further o_tx_start is issued.
- BPW = NB_DATA/8 bytes per word. Multi-byte words are little-endian: byte 0 is the LSB.
- RX_OP:
  - On i_rx_valid, o_alu_op <= i_rx_data[NB_OP-1:0]; bits above NB_OP are ignored.
  - Go to RX_A with the counter cleared.
- RX_A / RX_B: each accepted byte is written into byte lane [counter] of the operand; the counter increments. After BPW bytes, go to the next state and clear the counter.
- RX_SHAMT: on i_rx_valid, o_alu_shamt <= i_rx_data[4:0]; bits 7:5 are ignored. Go to EXEC.
- Operand registers change only when their byte is accepted. o_alu_* stay stable from capture until overwritten by the next command.
- EXEC:
  - Exactly one cycle; result_reg <= i_alu_result.
  - Last-byte-to-result latency is 1 cycle.
  - Go to TX.
- TX:
  - Drive o_tx_data = result_reg byte [counter] and pulse o_tx_start for 1 cycle.
  - Go to TX_WAIT.
  - The first o_tx_start occurs 2 cycles after the SHAMT byte's i_rx_valid.
- TX_WAIT:
  - Hold o_tx_data.
  - On i_tx_done: if counter == BPW-1, go to RX_OP with the counter cleared; otherwise increment the counter and go to TX.
- Dropped bytes: i_rx_valid in EXEC/TX/TX_WAIT is discarded, o_drop pulses 1 cycle, and no state change occurs.
- Ignored TX-done: i_tx_done outside TX_WAIT is ignored.
- Simultaneous events: i_rx_valid and i_tx_done in the same TX_WAIT cycle means the byte is dropped and the TX advance proceeds.
- Undefined opcodes are forwarded unchanged; the ALU's default result is returned.

Optional Feature:
- Macro ALU_UART_INTF_TIMEOUT_EN.
- Defined:
  - A counter runs in RX_A, RX_B and RX_SHAMT, and when in RX_OP with the byte counter nonzero.
  - It clears on every accepted byte.
  - On reaching TIMEOUT_CYCLES it forces RX_OP, clears the counters and sets o_alu_op=6'b111111.
- Undefined: the counter logic is absent and a partial command waits indefinitely.

Decomposition:
- Package alu_uart_intf_pkg holds:
  - State encoding: RX_OP, RX_A, RX_B, RX_SHAMT, EXEC, TX, TX_WAIT.
  - IDLE_OP=6'b111111.
  - NB_BYTE=8.
  - NB_SHAMT=5.
- One natural sub-module: alu_uart_intf_timeout (counter plus expire flag), instantiated only under the macro.

Test Plan:
- NB_DATA=8, bytes 0x20, 0x05, 0x03, 0x00 → o_alu_op=0x20, A=0x05, B=0x03; one o_tx_start 2 cycles after the last byte, o_tx_data=0x08; after i_tx_done, state RX_OP and o_busy=0.
- Bytes 0x22, 0x03, 0x05, 0x00 (SUB) → o_tx_data=0xFE. Bytes 0x03, 0x00, 0x80, 0xE2 (SRA, shamt 2 from 0xE2&0x1F) → o_tx_data=0xE0.
- NB_DATA=32: bytes 0x21, then A=0x78,0x56,0x34,0x12, then B=0x01,0x00,0x00,0x00, then shamt 0x00 → o_alu_data_A=0x12345678; TX bytes 0x79, 0x56, 0x34, 0x12 in order, each after the prior i_tx_done.
- Extra bytes: send 0xAA during TX_WAIT → o_drop pulses, o_tx_data unchanged. Assert i_rx_valid and i_tx_done together → byte dropped, TX advances.
- Reset mid-command: after bytes 0x20, 0x05, assert i_rst_n=0 for 1 cycle → o_alu_op=0x3F, A=0; a fresh 4-byte command returns the correct result.
- With ALU_UART_INTF_TIMEOUT_EN (TIMEOUT_CYCLES=16): send 0x20 only, wait 16 cycles → state RX_OP, o_alu_op=0x3F. The next bytes 0x24, 0x0F, 0x3C, 0x00 → 0x0C.
